// File: rtl/batpu_alu_pkg.sv
// batpu_alu_pkg: shared ALU opcode, self-test state and expected-result types.
package batpu_alu_pkg;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB, OP_NOR, OP_AND, OP_XOR, OP_RSH} alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} selftest_state_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int NUM_DIRECTED = 96;
  typedef struct packed {
    logic [15:0] res;
    logic        carry;
    logic        zero;
  } alu_expect_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction
endpackage

// File: rtl/alu_model.sv
// alu_model: combinational golden ALU (result zero-extended to 16 bits, carry, zero).
module alu_model
  import batpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output alu_expect_t      exp_o
);
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] res;
  logic             carry;
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    dif = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
    {carry, res} = {(WIDTH+1){1'b0}};
    case (alu_op_e'(op_i))
      OP_ADD: {carry, res} = sum;
      OP_SUB: {carry, res} = dif;
      OP_NOR: res = ~(a_i | b_i);
      OP_AND: res = a_i & b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_RSH: res = a_i >> 1;
      default: ;
    endcase
  end
  assign exp_o = '{res: 16'(res), carry: carry, zero: (res == '0)};
endmodule

// File: rtl/alu_selftest.sv
// alu_selftest: directed + LFSR sweep stimulus/checker for an ALU with DUT_LATENCY result delay.
// Define ALU_SELFTEST_STOP_ON_FAIL_EN to end the run on the first mismatch.
module alu_selftest
  import batpu_alu_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          NUM_RANDOM  = 64,
  parameter int          DUT_LATENCY = 0,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             clk_en,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic [2:0]       dut_op,
  input  logic [WIDTH-1:0] dut_res,
  input  logic             dut_carry,
  input  logic             dut_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail
);
  localparam int TOTAL = NUM_DIRECTED + NUM_RANDOM;
  typedef struct packed {
    logic        vld;
    logic [15:0] idx;
    alu_expect_t exp;
  } chk_t;
  selftest_state_e  state_q, state_d;
  logic [16:0]      idx_q;
  logic [15:0]      lfsr_q;
  logic [2:0]       rop_q, drain_q, vec_op;
  logic [WIDTH-1:0] vec_a, vec_b;
  alu_expect_t      vec_exp;
  chk_t             pipe_q [0:DUT_LATENCY];
  chk_t             chk;
  logic             is_dir, last_issue, issue, restart, mism, stop;
  logic [15:0]      err_inc, err_next;
  function automatic logic [WIDTH-1:0] corner(input logic [1:0] s);
    return s == 2'd0 ? '0 : s == 2'd1 ? WIDTH'(1) : s == 2'd2 ? {1'b1, {(WIDTH-1){1'b0}}} : '1;
  endfunction
  assign is_dir     = idx_q < 17'(NUM_DIRECTED);
  assign last_issue = idx_q == 17'(TOTAL - 1);
  assign vec_a      = is_dir ? corner(idx_q[3:2]) : lfsr_q[WIDTH-1:0];
  assign vec_b      = is_dir ? corner(idx_q[1:0]) : lfsr_q[15 -: WIDTH];
  assign vec_op     = is_dir ? idx_q[6:4] : rop_q;
  alu_model #(.WIDTH(WIDTH)) u_model (.a_i(vec_a), .b_i(vec_b), .op_i(vec_op), .exp_o(vec_exp));
  assign chk      = pipe_q[DUT_LATENCY];
  assign mism     = chk.vld && (16'(dut_res) != chk.exp.res || dut_carry != chk.exp.carry ||
                                dut_zero != chk.exp.zero);
  assign err_inc  = err_count == 16'hFFFF ? err_count : err_count + 16'd1;
  assign err_next = mism ? err_inc : err_count;
`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
  assign stop = mism;
`else
  assign stop = 1'b0;
`endif
  assign issue   = state_q == ST_RUN && !stop;
  assign restart = start && (state_q == ST_IDLE || state_q == ST_DONE);
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) state_q <= ST_IDLE;
    else if (clk_en) state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_RUN : state_q;
      ST_RUN:           state_d = last_issue ? ST_DRAIN : ST_RUN;
      ST_DRAIN:         state_d = drain_q == 3'(DUT_LATENCY) ? ST_DONE : ST_DRAIN;
      default:          state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_DONE;
  end
  always_comb begin
    busy = state_q == ST_RUN || state_q == ST_DRAIN;
    done = state_q == ST_DONE;
  end
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) begin
      idx_q      <= '0;
      lfsr_q     <= SEED;
      rop_q      <= '0;
      drain_q    <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_op     <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= 16'hFFFF;
      for (int i = 0; i <= DUT_LATENCY; i++) pipe_q[i] <= '0;
    end else if (clk_en) begin
      if (restart) begin
        idx_q      <= '0;
        lfsr_q     <= SEED;
        rop_q      <= '0;
        pass       <= 1'b0;
        err_count  <= '0;
        first_fail <= 16'hFFFF;
      end
      if (issue) begin
        dut_a  <= vec_a;
        dut_b  <= vec_b;
        dut_op <= vec_op;
        idx_q  <= idx_q + 17'd1;
        if (!is_dir) begin
          lfsr_q <= lfsr_next(lfsr_q);
          rop_q  <= rop_q == 3'd5 ? 3'd0 : rop_q + 3'd1;
        end
      end
      drain_q   <= state_q == ST_DRAIN ? drain_q + 3'd1 : 3'd0;
      pipe_q[0] <= '{vld: issue, idx: idx_q[15:0], exp: vec_exp};
      for (int i = 1; i <= DUT_LATENCY; i++) pipe_q[i] <= stop ? '0 : pipe_q[i-1];
      if (mism) begin
        err_count <= err_inc;
        if (first_fail == 16'hFFFF) first_fail <= chk.idx;
      end
      // final check lands on the same edge as the DONE transition, so use err_next
      if (state_q != ST_DONE && state_d == ST_DONE) pass <= err_next == 16'd0;
    end
endmodule

// File: tb/tb_alu_selftest.sv
// tb_alu_selftest: directed checks of alu_selftest against a behavioural ALU with fault knobs.
module tb_alu_selftest;
`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic        clk = 1'b0, async_rst = 1'b1, clk_en = 1'b1, start0 = 1'b0, start2 = 1'b0;
  logic        fault_c = 1'b0, fault_x = 1'b0, lat2 = 1'b1;
  logic [7:0]  a0, b0, res0, a2, b2, res2;
  logic [2:0]  op0, op2;
  logic        c0, z0, c2, z2, busy0, done0, pass0, busy2, done2, pass2;
  logic [15:0] err0, ff0, err2, ff2;
  logic [9:0]  d1 = '0, d2 = '0;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [9:0] ref_alu(input logic [7:0] a, b, input logic [2:0] op,
                                         input logic fc, fx);
    logic [8:0] t;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; if (fc) t[8] = 1'b0; end
      3'd1: t = {1'b0, a} + {1'b0, ~b} + 9'd1;
      3'd2: t = {1'b0, ~(a | b)};
      3'd3: t = {1'b0, a & b};
      3'd4: t = {1'b0, (a ^ b) ^ {7'd0, fx}};
      3'd5: t = {1'b0, a >> 1};
      default: t = '0;
    endcase
    return {t[8], t[7:0] == 8'd0, t[7:0]};
  endfunction

  always_comb {c0, z0, res0} = ref_alu(a0, b0, op0, fault_c, fault_x);
  always_comb {c2, z2, res2} = lat2 ? d2 : d1;
  always @(posedge clk) if (clk_en) begin
    d1 <= ref_alu(a2, b2, op2, 1'b0, 1'b0);
    d2 <= d1;
  end

  alu_selftest #(.WIDTH(8), .NUM_RANDOM(64), .DUT_LATENCY(0), .SEED(16'hACE1)) u0 (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_op(op0), .dut_res(res0), .dut_carry(c0), .dut_zero(z0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0));

  alu_selftest #(.WIDTH(8), .NUM_RANDOM(8), .DUT_LATENCY(2), .SEED(16'hACE1)) u2 (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .start(start2),
    .dut_a(a2), .dut_b(b2), .dut_op(op2), .dut_res(res2), .dut_carry(c2), .dut_zero(z2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail(ff2));

  task automatic model_sweep(input logic fc, fx, output int errs, output int first);
    logic [15:0] l;
    logic [7:0]  a, b;
    logic [2:0]  op;
    logic [7:0]  cs [4];
    cs = '{8'h00, 8'h01, 8'h80, 8'hFF};
    l = 16'hACE1;
    errs = 0;
    first = -1;
    for (int i = 0; i < 160; i++) begin
      if (i < 96) begin
        a = cs[(i % 16) / 4]; b = cs[i % 4]; op = 3'(i / 16);
      end else begin
        a = l[7:0]; b = l[15:8]; op = 3'((i - 96) % 6);
        l = l[0] ? (l >> 1) ^ 16'hB400 : l >> 1;
      end
      if (ref_alu(a, b, op, 1'b0, 1'b0) != ref_alu(a, b, op, fc, fx)) begin
        errs++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic run0(output int cyc);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 2000) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc >= 2000) begin failures++; $display("FAIL run0_timeout cycles=%0d limit=2000", cyc); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({a0, b0, op0} !== 19'd0) begin failures++; $display("FAIL rst_dut got=%h want=0", {a0, b0, op0}); end
    checks++;
    if ({busy0, done0, pass0} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b want=000", {busy0, done0, pass0}); end
    checks++;
    if (err0 !== 16'd0) begin failures++; $display("FAIL rst_err got=%h want=0", err0); end
    checks++;
    if (ff0 !== 16'hFFFF) begin failures++; $display("FAIL rst_ff got=%h want=ffff", ff0); end
    checks++;
    if ({busy2, ff2} !== {1'b0, 16'hFFFF}) begin failures++; $display("FAIL rst_u2 got=%h want=0ffff", {busy2, ff2}); end
    async_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0} !== 2'b00) begin failures++; $display("FAIL idle_hold got=%b want=00", {busy0, done0}); end
  endtask

  task automatic test_full_run;
    int cyc;
    logic [15:0] hold;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cyc = 0;
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL run_busy got=%b want=1", busy0); end
    while (!done0 && cyc < 2000) begin
      @(negedge clk); cyc++;
      start0 = cyc == 50;
      if (cyc == 1) begin
        checks++;
        if ({a0, b0, op0} !== {8'h00, 8'h00, 3'd0}) begin failures++; $display("FAIL vec0 got=%h want=%h", {a0, b0, op0}, {8'h00, 8'h00, 3'd0}); end
      end
      if (cyc == 11) begin
        checks++;
        if ({a0, b0, op0} !== {8'h80, 8'h80, 3'd0}) begin failures++; $display("FAIL vec10 got=%h want=%h", {a0, b0, op0}, {8'h80, 8'h80, 3'd0}); end
      end
      if (cyc == 40) begin
        checks++;
        if ({a0, b0, op0} !== {8'h01, 8'hFF, 3'd2}) begin failures++; $display("FAIL vec39 got=%h want=%h", {a0, b0, op0}, {8'h01, 8'hFF, 3'd2}); end
      end
      if (cyc == 97) begin
        checks++;
        if ({a0, b0, op0} !== {8'hE1, 8'hAC, 3'd0}) begin failures++; $display("FAIL vec96 got=%h want=%h", {a0, b0, op0}, {8'hE1, 8'hAC, 3'd0}); end
      end
      if (cyc == 98) begin
        checks++;
        if ({a0, b0, op0} !== {8'h70, 8'hE2, 3'd1}) begin failures++; $display("FAIL vec97 got=%h want=%h", {a0, b0, op0}, {8'h70, 8'hE2, 3'd1}); end
      end
    end
    start0 = 1'b0;
    checks++;
    if (cyc !== 161) begin failures++; $display("FAIL run_len got=%0d want=161", cyc); end
    checks++;
    if ({pass0, busy0} !== 2'b10) begin failures++; $display("FAIL run_pass got=%b want=10", {pass0, busy0}); end
    checks++;
    if ({err0, ff0} !== {16'd0, 16'hFFFF}) begin failures++; $display("FAIL run_counts got=%h want=0000ffff", {err0, ff0}); end
    checks++;
    if (op0 !== 3'd3) begin failures++; $display("FAIL last_op got=%0d want=3", op0); end
    hold = {a0, b0};
    repeat (3) @(negedge clk);
    checks++;
    if ({done0, a0, b0} !== {1'b1, hold}) begin failures++; $display("FAIL done_hold got=%h want=%h", {done0, a0, b0}, {1'b1, hold}); end
  endtask

  task automatic test_carry_fault;
    int cyc, errs, first;
    model_sweep(1'b1, 1'b0, errs, first);
    fault_c = 1'b1;
    run0(cyc);
    fault_c = 1'b0;
    checks++;
    if (ff0 !== 16'd7) begin failures++; $display("FAIL carry_first got=%0d want=7", ff0); end
    checks++;
    if (err0 !== 16'(STOP ? 1 : errs)) begin failures++; $display("FAIL carry_errs got=%0d want=%0d", err0, STOP ? 1 : errs); end
    checks++;
    if (pass0 !== 1'b0) begin failures++; $display("FAIL carry_pass got=%b want=0", pass0); end
    checks++;
    if (cyc !== (STOP ? 9 : 161)) begin failures++; $display("FAIL carry_len got=%0d want=%0d", cyc, STOP ? 9 : 161); end
  endtask

  task automatic test_xor_fault;
    int cyc;
    fault_x = 1'b1;
    run0(cyc);
    fault_x = 1'b0;
    checks++;
    if (ff0 !== 16'd64) begin failures++; $display("FAIL xor_first got=%0d want=64", ff0); end
    checks++;
    if (err0 !== 16'(STOP ? 1 : 26)) begin failures++; $display("FAIL xor_errs got=%0d want=%0d", err0, STOP ? 1 : 26); end
    checks++;
    if (cyc !== (STOP ? 66 : 161)) begin failures++; $display("FAIL xor_len got=%0d want=%0d", cyc, STOP ? 66 : 161); end
  endtask

  task automatic test_clk_en;
    int n, en, bad;
    logic [18:0] pv;
    logic pen;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n = 0; en = 0; bad = 0;
    while (!done0 && n < 3000) begin
      clk_en = n % 3 == 2;
      pen = clk_en;
      pv = {a0, b0, op0};
      @(negedge clk); n++;
      if (pen) en++;
      else if ({a0, b0, op0} !== pv) bad++;
    end
    clk_en = 1'b1;
    checks++;
    if (en !== 161 || n !== 483) begin failures++; $display("FAIL en_len got=%0d/%0d want=161/483", en, n); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL en_stable got=%0d want=0", bad); end
    checks++;
    if ({pass0, err0, ff0} !== {1'b1, 16'd0, 16'hFFFF}) begin failures++; $display("FAIL en_result got=%h want=%h", {pass0, err0, ff0}, {1'b1, 16'd0, 16'hFFFF}); end
  endtask

  task automatic test_async_reset;
    int cyc;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (41) @(negedge clk);
    checks++;
    if ({a0, b0, op0} !== {8'h80, 8'h00, 3'd2}) begin failures++; $display("FAIL vec40 got=%h want=%h", {a0, b0, op0}, {8'h80, 8'h00, 3'd2}); end
    #2 async_rst = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, pass0, a0, b0, op0} !== 22'd0) begin failures++; $display("FAIL arst_outs got=%h want=0", {busy0, done0, pass0, a0, b0, op0}); end
    checks++;
    if ({err0, ff0} !== {16'd0, 16'hFFFF}) begin failures++; $display("FAIL arst_counts got=%h want=0000ffff", {err0, ff0}); end
    @(negedge clk); async_rst = 1'b0;
    run0(cyc);
    checks++;
    if ({cyc == 161, pass0, err0} !== {1'b1, 1'b1, 16'd0}) begin failures++; $display("FAIL arst_rerun cycles=%0d pass=%b err=%0d want 161/1/0", cyc, pass0, err0); end
  endtask

  task automatic test_latency;
    int cyc;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 2000) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 107) begin failures++; $display("FAIL lat_len got=%0d want=107", cyc); end
    checks++;
    if ({pass2, err2, ff2} !== {1'b1, 16'd0, 16'hFFFF}) begin failures++; $display("FAIL lat_ok got=%h want=%h", {pass2, err2, ff2}, {1'b1, 16'd0, 16'hFFFF}); end
    lat2 = 1'b0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 2000) begin @(negedge clk); cyc++; end
    lat2 = 1'b1;
    checks++;
    if (done2 !== 1'b1) begin failures++; $display("FAIL lat_bad_done got=%b want=1", done2); end
    checks++;
    if (pass2 !== 1'b0 || (STOP ? err2 !== 16'd1 : err2 == 16'd0)) begin failures++; $display("FAIL lat_bad pass=%b err=%0d want pass=0 err>0", pass2, err2); end
    checks++;
    if (ff2 !== 16'd0) begin failures++; $display("FAIL lat_bad_first got=%0d want=0", ff2); end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_carry_fault;
    test_xor_fault;
    test_clk_en;
    test_async_reset;
    test_latency;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
